// File: rtl/reg_file_pkg.sv
// Shared types and default widths for the scoreboarded register file.
package reg_file_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    // True when idx addresses the hardwired zero register.
    function automatic logic rf_is_zero_reg(input int zero_reg, input logic [RF_ADDR_W-1:0] idx,
                                            input int addr_w);
        logic hit;
        hit = (zero_reg != 0);
        for (int b = 0; b < RF_ADDR_W; b++) begin
            if (b < addr_w && idx[b]) begin
                hit = 1'b0;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/reg_file_clr_fsm.sv
// Sequential clear engine: walks every entry once, one per clock, after clr_req_i.
module reg_file_clr_fsm
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_req_i,
    output logic              clr_busy_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_idx_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RF_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_we_o = 1'b0;
        unique case (state_q)
            RF_IDLE: begin
                if (clr_req_i) begin
                    state_d = RF_CLEAR;
                    cnt_d   = '0;
                end
            end
            RF_CLEAR: begin
                clr_we_o = 1'b1;
                cnt_d    = cnt_q + ADDR_W'(1);
                // The last entry is cleared on the same edge that returns to idle.
                if (cnt_q == LAST_IDX) begin
                    state_d = RF_IDLE;
                end
            end
            default: begin
                state_d = RF_IDLE;
            end
        endcase
    end

    assign clr_busy_o = (state_q == RF_CLEAR);
    assign clr_idx_o  = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// General-purpose register file: 2 async read ports, 1 write port, bypass,
// optional zero register, per-entry pending scoreboard and a sequential clear.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd0_idx,
    input  logic [ADDR_W-1:0] rd1_idx,
    output logic [DATA_W-1:0] rd0_data,
    output logic [DATA_W-1:0] rd1_data,
    output logic              rd0_busy,
    output logic              rd1_busy,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_idx,
    input  logic              clr_req,
    output logic              clr_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  sb_q, sb_d;

    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;
    logic              accept;
    logic              wr_ok, sb_ok;
    logic              zero0, zero1, byp0, byp1;

    reg_file_clr_fsm #(
        .ADDR_W(ADDR_W)
    ) u_clr_fsm (
        .clk_i     (clock),
        .rst_ni    (reset),
        .clr_req_i (clr_req),
        .clr_busy_o(clr_busy),
        .clr_we_o  (clr_we),
        .clr_idx_o (clr_idx)
    );

    // A clear request in idle wins over a write or set on the same edge.
    assign accept = !clr_busy && !clr_req;
    assign wr_ok  = accept && wr_en  && !((ZERO_REG != 0) && (wr_idx == '0));
    assign sb_ok  = accept && sb_set && !((ZERO_REG != 0) && (sb_idx == '0));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (clr_we) begin
            regs_q[clr_idx] <= '0;
        end else if (wr_ok) begin
            regs_q[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        sb_d = sb_q;
        if (clr_we) begin
            sb_d[clr_idx] = 1'b0;
        end else begin
            if (wr_ok) begin
                sb_d[wr_idx] = 1'b0;
            end
            // Applied after the write-clear so a same-index set wins.
            if (sb_ok) begin
                sb_d[sb_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    assign zero0 = (ZERO_REG != 0) && (rd0_idx == '0);
    assign zero1 = (ZERO_REG != 0) && (rd1_idx == '0);
    assign byp0  = (BYPASS != 0) && wr_en && !clr_busy && (wr_idx == rd0_idx);
    assign byp1  = (BYPASS != 0) && wr_en && !clr_busy && (wr_idx == rd1_idx);

    assign rd0_data = zero0 ? '0 : (byp0 ? wr_data : regs_q[rd0_idx]);
    assign rd1_data = zero1 ? '0 : (byp1 ? wr_data : regs_q[rd1_idx]);
    assign rd0_busy = !zero0 && !byp0 && sb_q[rd0_idx];
    assign rd1_busy = !zero1 && !byp1 && sb_q[rd1_idx];

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (reset && wr_ok) begin
            $display("reg_file_sb: r%0d <= 0x%h", wr_idx, wr_data);
        end
    end
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: three configurations driven in parallel and checked
// against an array-based model of the register/scoreboard/clear rules.
module tb_reg_file_sb;

    localparam int NI    = 3;
    localparam int DEPTH = 32;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_idx = '0;
    logic [31:0] wr_data = '0;
    logic [4:0]  rd0_idx = '0;
    logic [4:0]  rd1_idx = '0;
    logic        sb_set = 1'b0;
    logic [4:0]  sb_idx = '0;
    logic        clr_req = 1'b0;

    logic [31:0] r0d [NI];
    logic [31:0] r1d [NI];
    logic        r0b [NI];
    logic        r1b [NI];
    logic        cb  [NI];

    int nvec = 0;
    int nmis = 0;

    always #5 clock = ~clock;

    // Instance 0: defaults, 1: no bypass, 2: no zero register.
    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .rd0_idx(rd0_idx), .rd1_idx(rd1_idx), .rd0_data(r0d[0]), .rd1_data(r1d[0]),
        .rd0_busy(r0b[0]), .rd1_busy(r1b[0]), .sb_set(sb_set), .sb_idx(sb_idx),
        .clr_req(clr_req), .clr_busy(cb[0]));

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) u_nb (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .rd0_idx(rd0_idx), .rd1_idx(rd1_idx), .rd0_data(r0d[1]), .rd1_data(r1d[1]),
        .rd0_busy(r0b[1]), .rd1_busy(r1b[1]), .sb_set(sb_set), .sb_idx(sb_idx),
        .clr_req(clr_req), .clr_busy(cb[1]));

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(1)) u_nz (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .rd0_idx(rd0_idx), .rd1_idx(rd1_idx), .rd0_data(r0d[2]), .rd1_data(r1d[2]),
        .rd0_busy(r0b[2]), .rd1_busy(r1b[2]), .sb_set(sb_set), .sb_idx(sb_idx),
        .clr_req(clr_req), .clr_busy(cb[2]));

    // Reference model state.
    logic [31:0] m_regs [NI][DEPTH];
    bit          m_sb   [NI][DEPTH];
    bit          m_clr;
    int          m_cnt;

    function automatic bit zr_of(int i);
        return i != 2;
    endfunction

    function automatic bit bp_of(int i);
        return i != 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < DEPTH; k++) begin
                m_regs[i][k] = '0;
                m_sb[i][k]   = 1'b0;
            end
        end
        m_clr = 1'b0;
        m_cnt = 0;
    endtask

    task automatic model_edge();
        if (!reset) return;
        if (m_clr) begin
            for (int i = 0; i < NI; i++) begin
                m_regs[i][m_cnt] = '0;
                m_sb[i][m_cnt]   = 1'b0;
            end
            if (m_cnt == DEPTH - 1) m_clr = 1'b0;
            m_cnt = (m_cnt + 1) % DEPTH;
        end else if (clr_req) begin
            m_clr = 1'b1;
            m_cnt = 0;
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (wr_en && !(zr_of(i) && wr_idx == 0)) begin
                    m_regs[i][wr_idx] = wr_data;
                    m_sb[i][wr_idx]   = 1'b0;
                end
                if (sb_set && !(zr_of(i) && sb_idx == 0)) m_sb[i][sb_idx] = 1'b1;
            end
        end
    endtask

    function automatic void exp_rd(int i, logic [4:0] idx, output logic [31:0] d, output logic b);
        if (zr_of(i) && idx == 0) begin
            d = '0;
            b = 1'b0;
        end else if (bp_of(i) && wr_en && !m_clr && wr_idx == idx) begin
            d = wr_data;
            b = 1'b0;
        end else begin
            d = m_regs[i][idx];
            b = m_sb[i][idx];
        end
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_now(string tag);
        logic [31:0] d;
        logic        b;
        for (int i = 0; i < NI; i++) begin
            exp_rd(i, rd0_idx, d, b);
            chk($sformatf("%s_i%0d_rd0_data", tag, i), r0d[i], d);
            chk($sformatf("%s_i%0d_rd0_busy", tag, i), 32'(r0b[i]), 32'(b));
            exp_rd(i, rd1_idx, d, b);
            chk($sformatf("%s_i%0d_rd1_data", tag, i), r1d[i], d);
            chk($sformatf("%s_i%0d_rd1_busy", tag, i), 32'(r1b[i]), 32'(b));
            chk($sformatf("%s_i%0d_clr_busy", tag, i), 32'(cb[i]), 32'(m_clr));
        end
    endtask

    task automatic check_all(string tag);
        for (int k = 0; k < DEPTH; k++) begin
            rd0_idx = 5'(k);
            rd1_idx = 5'(DEPTH - 1 - k);
            #1;
            check_now(tag);
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic fill_regs();
        for (int k = 1; k < DEPTH; k++) begin
            wr_en   = 1'b1;
            wr_idx  = 5'(k);
            wr_data = 32'(k) * 32'h11;
            step();
        end
        wr_en = 1'b0;
    endtask

    typedef struct packed {
        logic        wr_en;
        logic [4:0]  wr_idx;
        logic [31:0] wr_data;
        logic [4:0]  rd0;
        logic [4:0]  rd1;
        logic        sb_set;
        logic [4:0]  sb_idx;
        logic [31:0] e_rd0;
        logic        e_b0;
        logic [31:0] e_rd1;
        logic        e_b1;
        logic [31:0] e_nb_rd0;
        logic [31:0] e_nz_rd0;
        logic        e_nz_b0;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        model_reset();

        tbl[0]  = '{1'b1, 5'd7, 32'h12345678, 5'd7, 5'd3, 1'b0, 5'd0,
                    32'h12345678, 1'b0, 32'h0, 1'b0, 32'h0, 32'h12345678, 1'b0};
        tbl[1]  = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd5, 1'b1, 5'd5,
                    32'h12345678, 1'b0, 32'h0, 1'b0, 32'h12345678, 32'h12345678, 1'b0};
        tbl[2]  = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd5, 1'b0, 5'd0,
                    32'h12345678, 1'b0, 32'h0, 1'b1, 32'h12345678, 32'h12345678, 1'b0};
        tbl[3]  = tbl[2];
        tbl[4]  = '{1'b1, 5'd5, 32'hA5, 5'd7, 5'd5, 1'b0, 5'd0,
                    32'h12345678, 1'b0, 32'hA5, 1'b0, 32'h12345678, 32'h12345678, 1'b0};
        tbl[5]  = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd5, 1'b0, 5'd0,
                    32'h12345678, 1'b0, 32'hA5, 1'b0, 32'h12345678, 32'h12345678, 1'b0};
        tbl[6]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 5'd0,
                    32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'hFFFFFFFF, 1'b0};
        tbl[7]  = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0,
                    32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'hFFFFFFFF, 1'b1};
        tbl[8]  = '{1'b1, 5'd9, 32'h99, 5'd9, 5'd9, 1'b1, 5'd9,
                    32'h99, 1'b0, 32'h99, 1'b0, 32'h0, 32'h99, 1'b0};
        tbl[9]  = '{1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0,
                    32'h99, 1'b1, 32'h99, 1'b1, 32'h99, 32'h99, 1'b1};
        tbl[10] = '{1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b1, 5'd9,
                    32'h99, 1'b1, 32'h99, 1'b1, 32'h99, 32'h99, 1'b1};
        tbl[11] = tbl[9];

        // Reset, then read two untouched entries.
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset   = 1'b1;
        rd0_idx = 5'd3;
        rd1_idx = 5'd31;
        #1;
        chk("rst_rd0_data", r0d[0], 32'h0);
        chk("rst_rd1_data", r1d[0], 32'h0);
        chk("rst_rd0_busy", 32'(r0b[0]), 32'h0);
        chk("rst_rd1_busy", 32'(r1b[0]), 32'h0);
        chk("rst_clr_busy", 32'(cb[0]), 32'h0);

        wr_en = 1'b1; wr_idx = 5'd3; wr_data = 32'hDEADBEEF;
        step();
        wr_en = 1'b0;
        #1;
        chk("wr3_readback", r0d[0], 32'hDEADBEEF);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("async_rst_rd0", r0d[0], 32'h0);
        @(negedge clock);
        reset = 1'b1;
        #1;

        // Table of directed vectors: bypass, scoreboard, zero register.
        for (int v = 0; v < 12; v++) begin
            wr_en   = tbl[v].wr_en;
            wr_idx  = tbl[v].wr_idx;
            wr_data = tbl[v].wr_data;
            rd0_idx = tbl[v].rd0;
            rd1_idx = tbl[v].rd1;
            sb_set  = tbl[v].sb_set;
            sb_idx  = tbl[v].sb_idx;
            #1;
            chk($sformatf("tbl%0d_rd0", v), r0d[0], tbl[v].e_rd0);
            chk($sformatf("tbl%0d_b0", v), 32'(r0b[0]), 32'(tbl[v].e_b0));
            chk($sformatf("tbl%0d_rd1", v), r1d[0], tbl[v].e_rd1);
            chk($sformatf("tbl%0d_b1", v), 32'(r1b[0]), 32'(tbl[v].e_b1));
            chk($sformatf("tbl%0d_nb_rd0", v), r0d[1], tbl[v].e_nb_rd0);
            chk($sformatf("tbl%0d_nz_rd0", v), r0d[2], tbl[v].e_nz_rd0);
            chk($sformatf("tbl%0d_nz_b0", v), 32'(r0b[2]), 32'(tbl[v].e_nz_b0));
            step();
        end
        wr_en  = 1'b0;
        sb_set = 1'b0;
        check_all("post_tbl");

        // Clear engine: fill, mark one pending, clear, try a write mid-clear.
        fill_regs();
        sb_set = 1'b1; sb_idx = 5'd4;
        step();
        sb_set  = 1'b0;
        clr_req = 1'b1;
        wr_en = 1'b1; wr_idx = 5'd6; wr_data = 32'h0BADF00D;
        step();
        clr_req = 1'b0;
        wr_en   = 1'b0;
        rd0_idx = 5'd5;
        rd1_idx = 5'd20;
        #1;
        n = 0;
        while (cb[0] === 1'b1 && n < 40) begin
            wr_en = 1'b0;
            if (n == 10) begin
                chk("clr_c10_reg5", r0d[0], 32'h0);
                chk("clr_c10_reg20", r1d[0], 32'h154);
            end
            if (n == 25) begin
                wr_en = 1'b1; wr_idx = 5'd20; wr_data = 32'hBAD0BAD0;
                #1;
            end
            check_now("clr_cyc");
            step();
            n++;
        end
        wr_en = 1'b0;
        chk("clr_len", 32'(n), 32'd32);
        check_all("clr_done");

        // Reset in the middle of a clear.
        fill_regs();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (12) step();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_mid_clr_busy", 32'(cb[0]), 32'h0);
        check_all("rst_mid_clr");
        @(negedge clock);
        reset = 1'b1;
        wr_en = 1'b1; wr_idx = 5'd2; wr_data = 32'h77;
        step();
        wr_en   = 1'b0;
        rd0_idx = 5'd2;
        #1;
        chk("post_rst_wr2", r0d[0], 32'h77);
        check_now("post_rst");

        // Randomised traffic against the model, clears included.
        for (int c = 0; c < 600; c++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_idx  = 5'($urandom_range(0, 7));
            wr_data = $urandom;
            sb_set  = 1'($urandom_range(0, 1));
            sb_idx  = 5'($urandom_range(0, 7));
            rd0_idx = ($urandom_range(0, 3) == 0) ? wr_idx : 5'($urandom_range(0, 7));
            rd1_idx = ($urandom_range(0, 3) == 0) ? sb_idx : 5'($urandom_range(0, 31));
            clr_req = ($urandom_range(0, 79) == 0);
            #1;
            check_now("rand");
            step();
        end
        wr_en   = 1'b0;
        sb_set  = 1'b0;
        clr_req = 1'b0;
        #1;
        check_all("rand_end");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
